// File: rtl/wom_writeback.sv
// WOM write-back: packs MULF halves, queues SUMF/MULF words in a FIFO
// and drains them to the WOM port with a req/ack handshake.
module wom_writeback #(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sum_valid,
  input  logic [AW-1:0] sum_addr,
  input  logic [31:0]   sum_data,
  output logic          sum_ready,
  input  logic          mul_valid,
  input  logic          mul_pos,
  input  logic [AW-1:0] mul_addr,
  input  logic [15:0]   mul_data,
  output logic          mul_ready,
  input  logic          flush,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [3:0]    mem_be,
  input  logic          mem_ack,
  output logic          busy,
  output logic          ovf_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic {IDLE, REQ} state_t;

  state_t state, state_nx;

  logic [AW-1:0] q_addr [DEPTH];
  logic [31:0]   q_data [DEPTH];
  logic [3:0]    q_be   [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, load_ptr;
  logic [CW-1:0] count;
  logic          full, empty;

  logic          half_pend, up_pend;
  logic [15:0]   hold_lo, up_hi;
  logic [AW-1:0] hold_addr, up_addr;
  logic [AW-1:0] sum_wa, mul_wa;
  logic          sum_fire, mul_fire, flush_fire, match;

  logic          push, push_ok, pop, load;
  logic [AW-1:0] push_addr;
  logic [31:0]   push_data;
  logic [3:0]    push_be;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // A deferred upper half must reach the FIFO before anything newer.
  assign sum_ready = ~rst & ~full & ~up_pend;
  assign mul_ready = ~rst & ~full & ~up_pend & ~sum_valid;

  assign sum_fire   = sum_valid & sum_ready;
  assign mul_fire   = mul_valid & mul_ready;
  assign flush_fire = flush & half_pend & ~full & ~up_pend
                    & ~sum_fire & ~mul_fire;

  assign sum_wa = sum_addr & ~AW'(3);
  assign mul_wa = mul_addr & ~AW'(3);
  assign match  = half_pend & (hold_addr == mul_wa);

  always_comb begin
    push      = 1'b0;
    push_addr = '0;
    push_data = '0;
    push_be   = '0;
    if (up_pend) begin
      push      = ~full;
      push_addr = up_addr;
      push_data = {up_hi, 16'h0};
      push_be   = 4'hC;
    end else if (sum_fire) begin
      push      = 1'b1;
      push_addr = sum_wa;
      push_data = sum_data;
      push_be   = 4'hF;
    end else if (mul_fire & mul_pos & match) begin
      push      = 1'b1;
      push_addr = mul_wa;
      push_data = {mul_data, hold_lo};
      push_be   = 4'hF;
    end else if (mul_fire & mul_pos & ~half_pend) begin
      push      = 1'b1;
      push_addr = mul_wa;
      push_data = {mul_data, 16'h0};
      push_be   = 4'hC;
    end else if ((mul_fire & half_pend) | flush_fire) begin
      push      = 1'b1;
      push_addr = hold_addr;
      push_data = {16'h0, hold_lo};
      push_be   = 4'h3;
    end
  end

  assign push_ok = push & ~full;
  assign pop     = (state == REQ) & mem_ack;

  always_ff @(posedge clk) begin
    if (rst) begin
      half_pend <= 1'b0;
      up_pend   <= 1'b0;
      hold_lo   <= '0;
      hold_addr <= '0;
      up_hi     <= '0;
      up_addr   <= '0;
    end else begin
      if (up_pend & ~full) up_pend <= 1'b0;
      if (mul_fire) begin
        if (!mul_pos) begin
          hold_lo   <= mul_data;
          hold_addr <= mul_wa;
          half_pend <= 1'b1;
        end else begin
          half_pend <= 1'b0;
          if (half_pend & ~match) begin
            up_pend <= 1'b1;
            up_hi   <= mul_data;
            up_addr <= mul_wa;
          end
        end
      end else if (flush_fire) begin
        half_pend <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      q_addr[wr_ptr] <= push_addr;
      q_data[wr_ptr] <= push_data;
      q_be[wr_ptr]   <= push_be;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ovf_err <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push & full) ovf_err <= 1'b1;
      count <= count + CW'(push_ok) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    load_ptr = rd_ptr;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          load     = 1'b1;
          state_nx = REQ;
        end
      end
      REQ: begin
        if (mem_ack) begin
          if (count > CW'(1)) begin
            load     = 1'b1;
            load_ptr = rd_ptr + 1'b1;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
    end else if (load) begin
      mem_addr  <= q_addr[load_ptr];
      mem_wdata <= q_data[load_ptr];
      mem_be    <= q_be[load_ptr];
    end
  end

  assign mem_req = (state == REQ);
  assign busy    = ~empty | mem_req | half_pend | up_pend;

endmodule

// File: tb/tb_wom_writeback.sv
// Bench for wom_writeback: directed cases then random traffic
// scored against a queue-based model of expected WOM writes.
module tb_wom_writeback;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sum_valid = 1'b0;
  logic [31:0] sum_addr = '0;
  logic [31:0] sum_data = '0;
  logic        sum_ready;
  logic        mul_valid = 1'b0;
  logic        mul_pos = 1'b0;
  logic [31:0] mul_addr = '0;
  logic [15:0] mul_data = '0;
  logic        mul_ready;
  logic        flush = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic        busy;
  logic        ovf_err;

  wom_writeback dut (
    .clk(clk), .rst(rst),
    .sum_valid(sum_valid), .sum_addr(sum_addr),
    .sum_data(sum_data), .sum_ready(sum_ready),
    .mul_valid(mul_valid), .mul_pos(mul_pos),
    .mul_addr(mul_addr), .mul_data(mul_data),
    .mul_ready(mul_ready), .flush(flush),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ack(mem_ack), .busy(busy), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;

  wr_t         exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          wr_cnt = 0;
  bit          ack_rand = 1'b0;
  bit          m_pend = 1'b0;
  logic [15:0] m_lo = '0;
  logic [31:0] m_addr = '0;

  task automatic chk(input string tag, input logic [63:0] o,
                     input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  function automatic void exp_push(logic [31:0] a, logic [31:0] d,
                                   logic [3:0] be);
    wr_t w;
    w.addr = a; w.data = d; w.be = be;
    exp_q.push_back(w);
  endfunction

  function automatic void model_sum(logic [31:0] a, logic [31:0] d);
    exp_push({a[31:2], 2'b00}, d, 4'hF);
  endfunction

  function automatic void model_mul(logic pos, logic [31:0] a,
                                    logic [15:0] d);
    logic [31:0] wa;
    wa = {a[31:2], 2'b00};
    if (!pos) begin
      if (m_pend) exp_push(m_addr, {16'h0, m_lo}, 4'h3);
      m_pend = 1'b1; m_lo = d; m_addr = wa;
    end else begin
      if (m_pend && m_addr == wa) begin
        exp_push(wa, {d, m_lo}, 4'hF);
      end else begin
        if (m_pend) exp_push(m_addr, {16'h0, m_lo}, 4'h3);
        exp_push(wa, {d, 16'h0}, 4'hC);
      end
      m_pend = 1'b0;
    end
  endfunction

  function automatic void model_flush();
    if (m_pend) exp_push(m_addr, {16'h0, m_lo}, 4'h3);
    m_pend = 1'b0;
  endfunction

  // Scoreboard: every handshake must match the oldest expected write.
  always @(negedge clk) begin
    if (!rst && mem_req && mem_ack) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_write: observed=%0h expected=none",
               mem_addr);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        chk("wr_addr", mem_addr, w.addr);
        chk("wr_data", mem_wdata, w.data);
        chk("wr_be", mem_be, w.be);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (ack_rand) mem_ack = 1'($urandom_range(0, 1));
  endtask

  task automatic send_sum(input logic [31:0] a, input logic [31:0] d);
    int n;
    sum_addr = a; sum_data = d; sum_valid = 1'b1; n = 0;
    #1;
    while (!sum_ready && n < 300) begin step(); #1; n++; end
    chk("sum_accept", sum_ready, 1'b1);
    step();
    sum_valid = 1'b0;
    model_sum(a, d);
  endtask

  task automatic send_mul(input logic p, input logic [31:0] a,
                          input logic [15:0] d);
    int n;
    mul_pos = p; mul_addr = a; mul_data = d; mul_valid = 1'b1; n = 0;
    #1;
    while (!mul_ready && n < 300) begin step(); #1; n++; end
    chk("mul_accept", mul_ready, 1'b1);
    step();
    mul_valid = 1'b0;
    model_mul(p, a, d);
  endtask

  task automatic do_flush();
    int n;
    flush = 1'b1; n = 0;
    #1;
    while (!sum_ready && n < 300) begin step(); #1; n++; end
    chk("flush_ready", sum_ready, 1'b1);
    step();
    flush = 1'b0;
    model_flush();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 1000) begin step(); n++; end
    chk("drain_busy", busy, 1'b0);
    chk("drain_exp", exp_q.size(), 0);
  endtask

  initial begin
    int base;
    int op;
    step();
    chk("rst_sum_ready", sum_ready, 1'b0);
    chk("rst_mul_ready", mul_ready, 1'b0);
    step();
    rst = 1'b0;
    #1;
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_mem_be", mem_be, 4'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ovf", ovf_err, 1'b0);

    // single SUM write with a one-cycle ack
    send_sum(32'h0, 32'hDEADBEEF);
    chk("t1_req_before", mem_req, 1'b0);
    step();
    chk("t1_req", mem_req, 1'b1);
    chk("t1_addr", mem_addr, 32'h0);
    chk("t1_data", mem_wdata, 32'hDEADBEEF);
    chk("t1_be", mem_be, 4'hF);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("t1_req_drop", mem_req, 1'b0);
    chk("t1_busy", busy, 1'b0);
    chk("t1_count", wr_cnt, 1);

    // MUL halves combine into one word
    ack_rand = 1'b1;
    base = wr_cnt;
    send_mul(1'b0, 32'h4, 16'h1111);
    send_mul(1'b1, 32'h4, 16'h2222);
    drain();
    chk("t2_count", wr_cnt - base, 1);

    // lone lower half forced out by flush
    base = wr_cnt;
    send_mul(1'b0, 32'h8, 16'h1111);
    chk("t3_busy_pend", busy, 1'b1);
    do_flush();
    drain();
    chk("t3_count", wr_cnt - base, 1);

    // back-pressure with the WOM stalled
    ack_rand = 1'b0;
    mem_ack = 1'b0;
    base = wr_cnt;
    for (int i = 0; i < 4; i++) send_sum(32'h100 + 4 * i, 32'hA000 + i);
    sum_addr = 32'h110; sum_data = 32'hA004; sum_valid = 1'b1;
    #1;
    chk("t4_full_ready", sum_ready, 1'b0);
    step(); step();
    chk("t4_full_ready2", sum_ready, 1'b0);
    chk("t4_ovf", ovf_err, 1'b0);
    mem_ack = 1'b1;
    send_sum(32'h110, 32'hA004);
    drain();
    mem_ack = 1'b0;
    chk("t4_count", wr_cnt - base, 5);
    chk("t4_ovf_end", ovf_err, 1'b0);

    // SUM wins over a simultaneous MUL
    ack_rand = 1'b1;
    sum_addr = 32'h20; sum_data = 32'h55667788; sum_valid = 1'b1;
    mul_pos = 1'b1; mul_addr = 32'h24; mul_data = 16'h9ABC;
    mul_valid = 1'b1;
    #1;
    chk("t5_mul_ready", mul_ready, 1'b0);
    chk("t5_sum_ready", sum_ready, 1'b1);
    step();
    sum_valid = 1'b0;
    model_sum(32'h20, 32'h55667788);
    send_mul(1'b1, 32'h24, 16'h9ABC);
    drain();

    // reset drops queued writes mid-transfer
    ack_rand = 1'b0;
    mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) send_sum(32'h200 + 4 * i, 32'hB000 + i);
    begin
      int n;
      n = 0;
      while (!mem_req && n < 10) begin step(); n++; end
    end
    chk("t6_req_high", mem_req, 1'b1);
    base = wr_cnt;
    rst = 1'b1;
    step();
    chk("t6_req_rst", mem_req, 1'b0);
    chk("t6_ready_rst", sum_ready, 1'b0);
    rst = 1'b0;
    exp_q.delete();
    m_pend = 1'b0;
    mem_ack = 1'b1;
    step(); step(); step();
    chk("t6_req_after", mem_req, 1'b0);
    chk("t6_busy_after", busy, 1'b0);
    chk("t6_no_writes", wr_cnt - base, 0);
    mem_ack = 1'b0;

    // random mixed traffic against the model
    ack_rand = 1'b1;
    for (int i = 0; i < 120; i++) begin
      op = $urandom_range(0, 9);
      if (op < 4)
        send_sum(32'h300 + 4 * $urandom_range(0, 3) + $urandom_range(0, 3),
                 $urandom);
      else if (op < 9)
        send_mul(1'($urandom_range(0, 1)),
                 32'h400 + 4 * $urandom_range(0, 2) + $urandom_range(0, 3),
                 16'($urandom));
      else
        do_flush();
    end
    do_flush();
    drain();
    chk("rand_ovf", ovf_err, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
